// File: rtl/single_port_ram_controller_if.sv
// rtl/single_port_ram_controller_if.sv - write, read-request and read-response channels of the RAM front-end
interface single_port_ram_controller_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     write_valid;
  logic                     write_ready;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [WIDTH-1:0]         write_data;
  logic                     read_request_valid;
  logic                     read_request_ready;
  logic [ADDRESS_WIDTH-1:0] read_request_address;
  logic                     read_response_valid;
  logic                     read_response_ready;
  logic [WIDTH-1:0]         read_response_data;

  modport slave (
    input  write_valid, write_address, write_data,
    output write_ready,
    input  read_request_valid, read_request_address,
    output read_request_ready,
    output read_response_valid, read_response_data,
    input  read_response_ready
  );

  modport master (
    output write_valid, write_address, write_data,
    input  write_ready,
    output read_request_valid, read_request_address,
    input  read_request_ready,
    input  read_response_valid, read_response_data,
    output read_response_ready
  );
endinterface

// File: rtl/single_port_ram_controller_response_buffer.sv
// rtl/single_port_ram_controller_response_buffer.sv - 2-entry in-order FIFO holding read data for the response channel
module single_port_ram_controller_response_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok, push_ok;

  always_comb begin
    pop_ok   = pop && (count_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
endmodule

// File: rtl/single_port_ram_controller.sv
// rtl/single_port_ram_controller.sv - arbitrates write and read requests onto one single-port RAM port
module single_port_ram_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  single_port_ram_controller_if.slave bus,
  output logic                     ram_access_enable,
  output logic                     ram_write,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0]         ram_write_data,
  input  logic [WIDTH-1:0]         ram_read_data
);
  localparam logic GRANT_WRITE = 1'b0;
  localparam logic GRANT_READ  = 1'b1;

  logic       last_grant_q, last_grant_d;
  logic       in_flight_q, in_flight_d;
  logic       grant_valid, grant;
  logic       write_eligible, read_eligible, read_can_issue;
  logic [1:0] occupancy;
  logic [2:0] pending;
  logic       buffer_valid;
  logic       pop;

  assign pop = buffer_valid && bus.read_response_ready;

  always_comb begin
    // Reads already issued or buffered must all fit in the two buffer slots.
    pending        = {1'b0, occupancy} + {2'b00, in_flight_q};
    read_can_issue = (pending < 3'd2) || ((pending == 3'd2) && pop);
    write_eligible = bus.write_valid;
    read_eligible  = bus.read_request_valid && read_can_issue;
    grant_valid    = write_eligible || read_eligible;
    grant          = GRANT_WRITE;
    last_grant_d   = last_grant_q;
    if (write_eligible && read_eligible) begin
      grant        = ~last_grant_q;
      last_grant_d = ~last_grant_q;
    end else if (read_eligible) begin
      grant = GRANT_READ;
    end
    bus.write_ready        = grant_valid && (grant == GRANT_WRITE);
    bus.read_request_ready = grant_valid && (grant == GRANT_READ);
    ram_access_enable      = grant_valid;
    ram_write              = grant_valid && (grant == GRANT_WRITE);
    ram_address            = (grant == GRANT_READ) ? bus.read_request_address : bus.write_address;
    ram_write_data         = bus.write_data;
    in_flight_d            = grant_valid && (grant == GRANT_READ);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= GRANT_READ;
      in_flight_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      in_flight_q  <= in_flight_d;
    end
  end

  single_port_ram_controller_response_buffer #(
    .WIDTH(WIDTH)
  ) u_response_buffer (
    .clock     (clock),
    .resetn    (resetn),
    .push      (in_flight_q),
    .push_data (ram_read_data),
    .pop       (pop),
    .out_valid (buffer_valid),
    .out_data  (bus.read_response_data),
    .count     (occupancy)
  );

  assign bus.read_response_valid = buffer_valid;
endmodule

// File: tb/tb_single_port_ram_controller.sv
// tb/tb_single_port_ram_controller.sv - directed table-driven bench for the RAM front-end with a behavioural RAM
module tb_single_port_ram_controller;
  logic       clock;
  logic       resetn;
  logic       ram_access_enable;
  logic       ram_write;
  logic [3:0] ram_address;
  logic [7:0] ram_write_data;
  logic [7:0] ram_read_data;
  logic [7:0] ram_mem [16];

  int checks   = 0;
  int failures = 0;

  single_port_ram_controller_if #(.WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  single_port_ram_controller #(.WIDTH(8), .DEPTH(16), .ADDRESS_WIDTH(4)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .bus               (bus),
    .ram_access_enable (ram_access_enable),
    .ram_write         (ram_write),
    .ram_address       (ram_address),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data)
  );

  always_ff @(posedge clock) begin
    if (ram_access_enable) begin
      if (ram_write) ram_mem[ram_address] <= ram_write_data;
      else           ram_read_data <= ram_mem[ram_address];
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wv;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       rv;
    logic [3:0] ra;
    logic       rr;
    logic       exp_wr;
    logic       exp_rr;
    logic       exp_rv;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [3:0] ra, input logic rr);
    bus.write_valid          = wv;
    bus.write_address        = wa;
    bus.write_data           = wd;
    bus.read_request_valid   = rv;
    bus.read_request_address = ra;
    bus.read_response_ready  = rr;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] mem_after_arb(input int a);
    return (a < 8) ? 8'(8'h10 + a) : 8'(8'hC0 + a);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Write 0xA5 @3, read @3, response two cycles after acceptance.
    vecs[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    // Both channels valid: grants alternate W,R starting with W; read k shows up two cycles later.
    for (int k = 1; k <= 18; k++) begin
      vec_t v;
      v = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      if (k <= 16) begin
        if (k % 2 == 1) begin
          v.wv = 1'b1; v.wa = 4'((k - 1) / 2); v.wd = 8'(8'h10 + (k - 1) / 2);
          v.rv = 1'b1; v.ra = 4'(8 + (k - 1) / 2);
          v.exp_wr = 1'b1;
        end else begin
          v.wv = (k / 2 < 8); v.wa = 4'((k / 2) % 8); v.wd = 8'(8'h10 + k / 2);
          v.rv = 1'b1; v.ra = 4'(8 + k / 2 - 1);
          v.exp_rr = 1'b1;
        end
      end
      if ((k % 2 == 0) && (k >= 4)) begin
        v.exp_rv = 1'b1; v.chk_data = 1'b1; v.exp_data = 8'(8'hC0 + 6 + k / 2);
      end
      vecs[4 + k] = v;
    end

    resetn = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_rsp_valid", 32'(bus.read_response_valid), 32'd0);
    check("reset_ram_enable", 32'(ram_access_enable), 32'd0);
    check("reset_read_ready", 32'(bus.read_request_ready), 32'd0);
    step();
    resetn = 1'b1;

    for (int a = 0; a < 16; a++) begin
      step();
      drive(1'b1, 4'(a), 8'(8'hC0 + a), 1'b0, 4'd0, 1'b1);
      @(negedge clock);
      check("prefill_wready", 32'(bus.write_ready), 32'd1);
    end

    for (int i = 0; i < 23; i++) begin
      step();
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].rr);
      @(negedge clock);
      check($sformatf("vec%0d_wready", i), 32'(bus.write_ready), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_rready", i), 32'(bus.read_request_ready), 32'(vecs[i].exp_rr));
      check($sformatf("vec%0d_rvalid", i), 32'(bus.read_response_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_rdata", i), 32'(bus.read_response_data), 32'(vecs[i].exp_data));
    end

    // 16 back-to-back reads, no bubbles.
    for (int c = 0; c < 19; c++) begin
      step();
      if (c < 16) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(c), 1'b1);
      else        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
      @(negedge clock);
      if (c < 16) check($sformatf("b2b%0d_rready", c), 32'(bus.read_request_ready), 32'd1);
      if (c >= 2 && c < 18) begin
        check($sformatf("b2b%0d_rvalid", c), 32'(bus.read_response_valid), 32'd1);
        check($sformatf("b2b%0d_rdata", c), 32'(bus.read_response_data), 32'(mem_after_arb(c - 2)));
      end else begin
        check($sformatf("b2b%0d_rvalid", c), 32'(bus.read_response_valid), 32'd0);
      end
    end

    // Stalled consumer: two reads admitted, then writes still flow.
    step(); drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0);
    @(negedge clock); check("bp0_rready", 32'(bus.read_request_ready), 32'd1);
    step(); drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b0);
    @(negedge clock); check("bp1_rready", 32'(bus.read_request_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step(); drive(1'b1, 4'(12 + c), 8'(8'h77 + c), 1'b1, 4'd2, 1'b0);
      @(negedge clock);
      check($sformatf("bp_stall%0d_rready", c), 32'(bus.read_request_ready), 32'd0);
      check($sformatf("bp_stall%0d_wready", c), 32'(bus.write_ready), 32'd1);
      check($sformatf("bp_stall%0d_rdata", c), 32'(bus.read_response_data), 32'h10);
    end
    step(); drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    @(negedge clock);
    check("bp_rel0_rvalid", 32'(bus.read_response_valid), 32'd1);
    check("bp_rel0_rdata", 32'(bus.read_response_data), 32'h10);
    step();
    @(negedge clock);
    check("bp_rel1_rvalid", 32'(bus.read_response_valid), 32'd1);
    check("bp_rel1_rdata", 32'(bus.read_response_data), 32'h11);
    step();
    @(negedge clock);
    check("bp_rel2_rvalid", 32'(bus.read_response_valid), 32'd0);
    step(); drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b1);
    step(); drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    step();
    @(negedge clock);
    check("bp_write_landed", 32'(bus.read_response_data), 32'h77);

    // Reset with one read in flight and one buffered.
    step(); drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
    step(); drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b0);
    step(); drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    check("rst_pre_rvalid", 32'(bus.read_response_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_async_rvalid", 32'(bus.read_response_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clock);
      check($sformatf("rst_after%0d_rvalid", c), 32'(bus.read_response_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
